// File: rtl/lru_ctrl.sv
// Tree-PLRU sequencer for a 4-way cache: reads a set's state, returns hit/victim way,
// writes the updated state back one cycle later, and sweeps the array clear on flush.
module lru_ctrl #(
  parameter int S_INDEX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [S_INDEX-1:0] req_set,
  input  logic               req_hit,
  input  logic [1:0]         req_way,
  output logic               resp_valid,
  output logic [1:0]         resp_way,
  input  logic               flush_req,
  output logic               flush_done,
  output logic               lru_csb0,
  output logic               lru_web0,
  output logic [S_INDEX-1:0] lru_addr0,
  output logic [2:0]         lru_din0,
  input  logic [2:0]         lru_dout0,
  output logic               lru_csb1,
  output logic               lru_web1,
  output logic [S_INDEX-1:0] lru_addr1,
  output logic [2:0]         lru_din1,
  input  logic [2:0]         lru_dout1
);

  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam logic [S_INDEX:0] CNT_LAST = (S_INDEX + 1)'(NUM_SETS - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t             state, state_nxt;
  logic [S_INDEX:0]   cnt, cnt_nxt;
  logic               accept;
  logic [1:0]         way_sel;

  logic               vld_p1;
  logic               hit_p1;
  logic [S_INDEX-1:0] set_p1;
  logic [1:0]         way_p1;

  logic               unused;
  assign unused = ^lru_dout1;

  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    if (!b[0]) plru_victim = b[1] ? 2'd1 : 2'd0;
    else       plru_victim = b[2] ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [2:0] plru_update(input logic [2:0] b, input logic [1:0] w);
    plru_update = b;
    case (w)
      2'd0: begin plru_update[0] = 1'b1; plru_update[1] = 1'b1; end
      2'd1: begin plru_update[0] = 1'b1; plru_update[1] = 1'b0; end
      2'd2: begin plru_update[0] = 1'b0; plru_update[2] = 1'b1; end
      default: begin plru_update[0] = 1'b0; plru_update[2] = 1'b0; end
    endcase
  endfunction

  assign lru_web0 = 1'b1;
  assign lru_din0 = 3'b000;
  assign way_sel  = hit_p1 ? way_p1 : plru_victim(lru_dout0);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_way   = 2'd0;
    flush_done = 1'b0;
    lru_csb0   = 1'b1;
    lru_addr0  = '0;
    lru_csb1   = 1'b1;
    lru_web1   = 1'b1;
    lru_addr1  = '0;
    lru_din1   = 3'b000;

    if (!rst) begin
      // stage 1: respond and write back the updated state
      if (vld_p1) begin
        resp_valid = 1'b1;
        resp_way   = way_sel;
        lru_csb1   = 1'b0;
        lru_web1   = 1'b0;
        lru_addr1  = set_p1;
        lru_din1   = plru_update(lru_dout0, way_sel);
      end

      case (state)
        IDLE: begin
          if (flush_req) begin
            state_nxt = FLUSH;
            cnt_nxt   = '0;
          end else begin
            req_ready = 1'b1;
            // stage 0: issue the read and capture the request
            if (req_valid) begin
              accept    = 1'b1;
              lru_csb0  = 1'b0;
              lru_addr0 = req_set;
            end
          end
        end
        FLUSH: begin
          lru_csb1  = 1'b0;
          lru_web1  = 1'b0;
          lru_addr1 = cnt[S_INDEX-1:0];
          lru_din1  = 3'b000;
          cnt_nxt   = cnt + 1'b1;
          if (cnt == CNT_LAST) state_nxt = DONE;
        end
        DONE: begin
          flush_done = 1'b1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      vld_p1 <= 1'b0;
      hit_p1 <= 1'b0;
      set_p1 <= '0;
      way_p1 <= 2'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      vld_p1 <= accept;
      if (accept) begin
        hit_p1 <= req_hit;
        set_p1 <= req_set;
        way_p1 <= req_way;
      end
    end
  end

endmodule
